// File: rtl/router4_pipeline_pkg.sv
// router4_pipeline_pkg: shared fan-out width constants for the 1-to-4 router
package router4_pipeline_pkg;
    localparam int N_OUT  = 4;
    localparam int MASK_W = N_OUT;
endpackage

// File: rtl/router4_pipeline_if.sv
// router4_pipeline_if: upstream valid/ready bus plus four downstream valid/ready lanes
interface router4_pipeline_if
    import router4_pipeline_pkg::*;
#(
    parameter int DW = 8
) ();
    logic                  valid_in;
    logic [MASK_W-1:0]     dest_in;
    logic [DW-1:0]         data_in;
    logic                  ready_out;
    logic [N_OUT-1:0]      valid_out;
    logic [N_OUT*DW-1:0]   data_out;
    logic [N_OUT-1:0]      ready_in;
    logic                  drop_out;

    modport slave (
        input  valid_in, dest_in, data_in, ready_in,
        output ready_out, valid_out, data_out, drop_out
    );

    modport master (
        output valid_in, dest_in, data_in, ready_in,
        input  ready_out, valid_out, data_out, drop_out
    );
endinterface

// File: rtl/router4_pipeline_fifo.sv
// router_fifo: small power-of-two circular FIFO with registered occupancy count
module router_fifo #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DW-1:0]               push_data,
    input  logic                        pop,
    output logic [DW-1:0]               head_data,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty;
    assign empty     = r_cnt == '0;
    assign full      = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign count     = r_cnt;
    assign head_data = r_mem[r_rp];

    // pointers wrap naturally at the power-of-two depth; push+pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // storage needs no reset: contents are only visible through a nonzero count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= push_data;
    end
endmodule

// File: rtl/router4_pipeline.sv
// router4_pipeline: 1-to-4 multicast valid/ready router with per-output FIFOs
module router4_pipeline
    import router4_pipeline_pkg::*;
#(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    router4_pipeline_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              r_s_valid;
    logic [MASK_W-1:0] r_s_mask;
    logic [DW-1:0]     r_s_data;
    logic              r_drop;
    logic [N_OUT-1:0]  w_full;
    logic [N_OUT-1:0]  w_empty;
    logic [N_OUT-1:0]  w_push;
    logic [N_OUT-1:0]  w_pop;
    logic [CW-1:0]     w_count [N_OUT];
    logic              w_fire;
    logic              w_accept;

    // a beat fires only when every selected FIFO has room, so multicast is all-or-nothing
    assign w_fire        = r_s_valid & ~|(r_s_mask & w_full);
    assign bus.ready_out = ~rst & (~r_s_valid | w_fire);
    assign w_accept      = bus.valid_in & bus.ready_out;
    assign w_push        = r_s_mask & {N_OUT{w_fire}};
    assign w_pop         = ~w_empty & bus.ready_in;
    assign bus.drop_out  = r_drop;

    // ingress stage loads on accept, empties when its beat fires; zero-mask fires pulse drop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_valid <= 1'b0;
            r_s_mask  <= '0;
            r_s_data  <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= w_fire & ~|r_s_mask;
            if (w_accept) begin
                r_s_valid <= 1'b1;
                r_s_mask  <= bus.dest_in;
                r_s_data  <= bus.data_in;
            end else if (w_fire) begin
                r_s_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        router_fifo #(
            .DW         (DW),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (w_push[i]),
            .push_data (r_s_data),
            .pop       (w_pop[i]),
            .head_data (bus.data_out[i*DW +: DW]),
            .empty     (w_empty[i]),
            .full      (w_full[i]),
            .count     (w_count[i])
        );
        assign bus.valid_out[i] = w_count[i] != '0;
    end
endmodule

// File: tb/tb_router4_pipeline.sv
// tb_router4_pipeline: directed and random checks of the router against a queue-based model
module tb_router4_pipeline;
    import router4_pipeline_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    router4_pipeline_if #(.DW(DW)) bus ();

    router4_pipeline #(
        .DW         (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #50 clk = ~clk;

    int n_checks   = 0;
    int n_errors   = 0;
    int drops_seen = 0;

    logic [DW-1:0] q [N_OUT][$];
    logic          m_sv   = 1'b0;
    logic [3:0]    m_sm   = '0;
    logic [DW-1:0] m_sd   = '0;
    logic          m_drop = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_fire();
        logic f = m_sv;
        for (int i = 0; i < N_OUT; i++)
            if (m_sm[i] && q[i].size() >= DEPTH) f = 1'b0;
        return f;
    endfunction

    function automatic logic m_ready();
        return !rst && (!m_sv || m_fire());
    endfunction

    // compare outputs just before the edge, then advance the model through that edge
    task automatic tick();
        logic [N_OUT-1:0] ev;
        logic fire;
        logic acc;
        #70;
        for (int i = 0; i < N_OUT; i++) ev[i] = q[i].size() != 0;
        check("valid_out", bus.valid_out, ev);
        for (int i = 0; i < N_OUT; i++)
            if (ev[i]) check($sformatf("data_out[%0d]", i), bus.data_out[i*DW +: DW], q[i][0]);
        check("ready_out", bus.ready_out, m_ready());
        check("drop_out", bus.drop_out, m_drop);
        if (bus.drop_out === 1'b1) drops_seen++;
        fire = m_fire();
        acc  = bus.valid_in && m_ready();
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) q[i].delete();
            m_sv   = 1'b0;
            m_drop = 1'b0;
        end else begin
            for (int i = 0; i < N_OUT; i++)
                if (ev[i] && bus.ready_in[i]) void'(q[i].pop_front());
            if (fire)
                for (int i = 0; i < N_OUT; i++)
                    if (m_sm[i]) q[i].push_back(m_sd);
            m_drop = fire && m_sm == 4'b0000;
            if (acc) begin
                m_sv = 1'b1;
                m_sm = bus.dest_in;
                m_sd = bus.data_in;
            end else if (fire) begin
                m_sv = 1'b0;
            end
        end
        @(posedge clk);
        #10;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input logic [3:0] d, input logic [DW-1:0] v);
        logic ok = 1'b0;
        bus.valid_in = 1'b1;
        bus.dest_in  = d;
        bus.data_in  = v;
        for (int k = 0; k < 40 && !ok; k++) begin
            ok = m_ready();
            tick();
        end
        bus.valid_in = 1'b0;
        check("send_accepted", ok, 1'b1);
    endtask

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic pend = 1'b0;
        bus.valid_in = 1'b0;
        bus.dest_in  = '0;
        bus.data_in  = '0;
        bus.ready_in = 4'hF;
        @(posedge clk);
        #10;
        tick();
        rst = 1'b0;
        #1;
        check("reset_release_ready", bus.ready_out, 1'b1);

        send(4'b0001, 8'hA5);
        tick();
        check("t1_valid", bus.valid_out, 4'b0001);
        check("t1_data", bus.data_out[7:0], 8'hA5);
        tick();
        check("t1_single_beat", bus.valid_out, 4'b0000);

        send(4'b1011, 8'h3C);
        tick();
        check("t2_valid", bus.valid_out, 4'b1011);
        check("t2_slice0", bus.data_out[7:0], 8'h3C);
        check("t2_slice1", bus.data_out[15:8], 8'h3C);
        check("t2_slice3", bus.data_out[31:24], 8'h3C);
        idle(2);

        bus.ready_in = 4'b1011;
        send(4'b0100, 8'h01);
        send(4'b0100, 8'h02);
        send(4'b0100, 8'h03);
        check("t3_ready_low", bus.ready_out, 1'b0);
        check("t3_head", bus.data_out[23:16], 8'h01);
        idle(2);
        bus.ready_in = 4'hF;
        idle(6);
        check("t3_ready_back", bus.ready_out, 1'b1);
        check("t3_drained", bus.valid_out, 4'b0000);

        bus.ready_in = 4'b1011;
        send(4'b0100, 8'h11);
        send(4'b0100, 8'h12);
        idle(1);
        check("t4_ready_free", bus.ready_out, 1'b1);
        send(4'b0001, 8'h77);
        tick();
        check("t4_out0_valid", bus.valid_out, 4'b0101);
        check("t4_out0_data", bus.data_out[7:0], 8'h77);
        send(4'b0100, 8'h13);
        bus.valid_in = 1'b1;
        bus.dest_in  = 4'b0001;
        bus.data_in  = 8'h78;
        for (int k = 0; k < 3; k++) begin
            check("t4_blocked", bus.ready_out, 1'b0);
            tick();
        end
        bus.ready_in = 4'hF;
        send(4'b0001, 8'h78);
        idle(6);

        drops_seen = 0;
        send(4'b0000, 8'hFF);
        idle(4);
        check("t5_drop_count", drops_seen, 1);
        send(4'b0010, 8'h55);
        idle(3);

        bus.ready_in = 4'b1100;
        send(4'b0001, 8'hA1);
        send(4'b0010, 8'hB1);
        send(4'b0011, 8'hC1);
        send(4'b0001, 8'hA2);
        idle(1);
        rst = 1'b1;
        tick();
        check("t6_valid_low", bus.valid_out, 4'b0000);
        check("t6_drop_low", bus.drop_out, 1'b0);
        check("t6_ready_low", bus.ready_out, 1'b0);
        rst = 1'b0;
        #1;
        check("t6_ready_release", bus.ready_out, 1'b1);
        bus.ready_in = 4'hF;
        idle(5);

        for (int c = 0; c < 1500; c++) begin
            if (!pend) begin
                bus.valid_in = $urandom_range(0, 99) < 60;
                bus.dest_in  = 4'($urandom);
                bus.data_in  = 8'($urandom);
            end
            bus.ready_in = 4'($urandom);
            rst  = $urandom_range(0, 199) == 0;
            pend = bus.valid_in && !m_ready();
            tick();
        end
        rst = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 4'hF;
        idle(6);
        check("final_empty", bus.valid_out, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
